// File: rtl/adc_sample_averager.sv
// adc_sample_averager: syncs the deserializer new-data flag into clk_50MHz and
// emits the average, min and max of every 2^LOG2_AVG captured samples.
module adc_sample_averager #(
  parameter int LOG2_AVG = 4,
  parameter int DATA_W   = 16
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              avg_clear,
  input  logic              new_data_flag,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] avg_data,
  output logic [DATA_W-1:0] avg_min,
  output logic [DATA_W-1:0] avg_max,
  output logic              avg_valid,
  output logic [LOG2_AVG:0] fill_count
);
  localparam int AW = DATA_W + LOG2_AVG;
  localparam int CW = LOG2_AVG + 1;
  localparam logic [LOG2_AVG:0] N = CW'(1) << LOG2_AVG;
  typedef enum logic {ACCUM, DUMP} state_t;
  state_t            state_q, state_d;
  logic [2:0]        sync_q;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              vld_q, vld_d;
  logic [AW-1:0]     acc_q, acc_d, base_acc;
  logic [LOG2_AVG:0] cnt_q, cnt_d, base_cnt;
  logic [DATA_W-1:0] min_q, min_d, base_min, max_q, max_d, base_max;
  logic [DATA_W-1:0] avg_q, avg_d, omin_q, omin_d, omax_q, omax_d;
  logic              valid_q, valid_d;
  logic              edge_w, abort, dump;
  assign edge_w = sync_q[1] & ~sync_q[2];
  assign abort  = ~enable | avg_clear;
  assign dump   = (state_q == DUMP) & ~abort;
  always_comb begin
    sample_d = edge_w ? adc_data : sample_q;
    vld_d    = edge_w & ~abort;
    // A sample landing in the DUMP cycle starts the next window instead of being lost
    base_acc = (state_q == DUMP) ? '0 : acc_q;
    base_cnt = (state_q == DUMP) ? '0 : cnt_q;
    base_min = (state_q == DUMP) ? '1 : min_q;
    base_max = (state_q == DUMP) ? '0 : max_q;
    acc_d    = abort ? '0 : vld_q ? base_acc + AW'(sample_q) : base_acc;
    cnt_d    = abort ? '0 : vld_q ? base_cnt + CW'(1) : base_cnt;
    min_d    = abort ? '1 : (vld_q && sample_q < base_min) ? sample_q : base_min;
    max_d    = abort ? '0 : (vld_q && sample_q > base_max) ? sample_q : base_max;
    state_d  = (!abort && vld_q && cnt_d == N) ? DUMP : ACCUM;
    valid_d  = dump;
    avg_d    = dump ? acc_q[AW-1:LOG2_AVG] : avg_q;
    omin_d   = dump ? min_q : omin_q;
    omax_d   = dump ? max_q : omax_q;
  end
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ACCUM;
      sync_q   <= '0;
      sample_q <= '0;
      vld_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      min_q    <= '1;
      max_q    <= '0;
      avg_q    <= '0;
      omin_q   <= '0;
      omax_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[1:0], new_data_flag};
      sample_q <= sample_d;
      vld_q    <= vld_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      min_q    <= min_d;
      max_q    <= max_d;
      avg_q    <= avg_d;
      omin_q   <= omin_d;
      omax_q   <= omax_d;
      valid_q  <= valid_d;
    end
  end
  assign avg_data   = avg_q;
  assign avg_min    = omin_q;
  assign avg_max    = omax_q;
  assign avg_valid  = valid_q;
  assign fill_count = cnt_q;
endmodule

// File: tb/tb_adc_sample_averager.sv
// tb_adc_sample_averager: scoreboard bench for a 16-sample and a pass-through averager.
module tb_adc_sample_averager;
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst_n, en, clr, flag;
  logic [15:0] data;
  logic [15:0] a4, mn4, mx4, a0, mn0, mx0;
  logic v4, v0;
  logic [4:0] fc4;
  logic [0:0] fc0;
  typedef struct packed {logic [15:0] a; logic [15:0] mn; logic [15:0] mx;} res_t;
  res_t q4[$], q0[$];
  int win[$];
  int n_vec = 0, n_err = 0;

  adc_sample_averager #(.LOG2_AVG(4), .DATA_W(16)) dut4 (
    .clk_50MHz(clk), .reset_n(rst_n), .enable(en), .avg_clear(clr),
    .new_data_flag(flag), .adc_data(data), .avg_data(a4), .avg_min(mn4),
    .avg_max(mx4), .avg_valid(v4), .fill_count(fc4));
  adc_sample_averager #(.LOG2_AVG(0), .DATA_W(16)) dut0 (
    .clk_50MHz(clk), .reset_n(rst_n), .enable(en), .avg_clear(clr),
    .new_data_flag(flag), .adc_data(data), .avg_data(a0), .avg_min(mn0),
    .avg_max(mx0), .avg_valid(v0), .fill_count(fc0));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t window_result();
    int s = 0;
    int lo = 32'hFFFF, hi = 0;
    res_t r;
    foreach (win[i]) begin
      s += win[i];
      if (win[i] < lo) lo = win[i];
      if (win[i] > hi) hi = win[i];
    end
    r.a  = 16'(s / 16);
    r.mn = 16'(lo);
    r.mx = 16'(hi);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected results are queued before the flag goes up; the monitor checks them.
  task automatic send(input logic [15:0] d, input int hold, input bit lat);
    if (en) begin
      win.push_back(int'(d));
      q0.push_back('{d, d, d});
      if (win.size() == 16) begin
        q4.push_back(window_result());
        win.delete();
      end
    end
    data = d;
    flag = 1'b1;
    if (lat) begin
      tick(4);
      chk("latency_early", 64'(v4), 64'(1'b0));
      tick(1);
      chk("latency_edge5", 64'(v4), 64'(1'b1));
      tick(hold - 5);
    end else tick(hold);
    flag = 1'b0;
    tick(6);
    chk("fill_count", 64'(fc4), 64'(win.size()));
    chk("fill_count0", 64'(fc0), 64'd0);
  endtask

  task automatic clear_pulse();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    win.delete();
  endtask

  always @(negedge clk) begin : monitor
    res_t e;
    if (v4) begin
      if (q4.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_valid4: avg %0h min %0h max %0h", a4, mn4, mx4);
      end else begin
        e = q4.pop_front();
        chk("avg4", 64'(a4), 64'(e.a));
        chk("min4", 64'(mn4), 64'(e.mn));
        chk("max4", 64'(mx4), 64'(e.mx));
      end
    end
    if (v0) begin
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_valid0: avg %0h", a0);
      end else begin
        e = q0.pop_front();
        chk("avg0", 64'(a0), 64'(e.a));
        chk("min0", 64'(mn0), 64'(e.mn));
        chk("max0", 64'(mx0), 64'(e.mx));
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; flag = 1'b0; data = '0;
    tick(3);
    chk("rst_avg", 64'(a4), 64'd0);
    chk("rst_min", 64'(mn4), 64'd0);
    chk("rst_max", 64'(mx4), 64'd0);
    chk("rst_valid", 64'(v4), 64'd0);
    chk("rst_fill", 64'(fc4), 64'd0);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 16; i++) send(16'h1234, $urandom_range(2, 5), 1'b0);
    for (int i = 0; i < 16; i++) send(16'(i), $urandom_range(2, 5), 1'b0);
    for (int i = 0; i < 16; i++) send(16'hFFFF, $urandom_range(2, 5), 1'b0);
    send(16'h0777, 40, 1'b0);
    for (int i = 0; i < 14; i++) send(16'($urandom), $urandom_range(2, 5), 1'b0);
    send(16'h0ABC, 8, 1'b1);
    for (int i = 0; i < 8; i++) send(16'h0100, 3, 1'b0);
    clear_pulse();
    for (int i = 0; i < 16; i++) send(16'h0200, 3, 1'b0);
    for (int i = 0; i < 5; i++) send(16'h0050, 3, 1'b0);
    en = 1'b0;
    tick(3);
    win.delete();
    send(16'h7777, 4, 1'b0);
    en = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) send(16'h0050, 3, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 14) == 0) clear_pulse();
      send(16'($urandom), $urandom_range(2, 6), 1'b0);
    end
    clear_pulse();
    for (int i = 0; i < 5; i++) send(16'h3333, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_avg", 64'(a4), 64'd0);
    chk("mid_rst_min", 64'(mn4), 64'd0);
    chk("mid_rst_max", 64'(mx4), 64'd0);
    chk("mid_rst_valid", 64'(v4), 64'd0);
    chk("mid_rst_fill", 64'(fc4), 64'd0);
    chk("mid_rst_avg0", 64'(a0), 64'd0);
    tick(3);
    rst_n = 1'b1;
    win.delete();
    tick(10);
    chk("pending4", 64'(q4.size()), 64'd0);
    chk("pending0", 64'(q0.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
- Consumes the 16-bit serial-ADC deserializer output: a new-data flag plus a parallel data word, both generated in the divided SCLK domain.
- Brings the flag into the clk_50MHz domain and captures each sample once.
- Accumulates 2^LOG2_AVG consecutive samples and emits a decimated average with window min/max for the Raman servo/readout logic.

Parameters:
LOG2_AVG, 4, log2 of samples per window (0..8); window size N = 2^LOG2_AVG
DATA_W, 16, ADC sample width; samples are unsigned straight binary

Ports:
clk_50MHz  input  1  system clock; all logic on posedge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  level; 1 = accept samples, 0 = abort window and ignore samples
avg_clear  input  1  synchronous single-cycle pulse; discards the partial window
new_data_flag  input  1  deserializer new-data flag (SCLK domain, high at least 2 clk_50MHz cycles)
adc_data  input  DATA_W  deserializer data word; stable while new_data_flag is high and until the next flag
avg_data  output  DATA_W  window average
avg_min  output  DATA_W  minimum sample in the window
avg_max  output  DATA_W  maximum sample in the window
avg_valid  output  1  one-cycle pulse when avg_data, avg_min and avg_max update
fill_count  output  LOG2_AVG+1  samples accumulated in the current window

Behaviour:
- Reset: all outputs 0. Accumulator 0, count 0, internal min = all-ones, internal max = 0, sync flops 0, state ACCUM.
- CDC:
  - new_data_flag passes through 2 flops (s1, s2) plus history flop s3.
  - edge = s2 & !s3.
  - A flag held high for any length produces exactly one edge.
- Capture: on the edge cycle, adc_data is latched into sample_reg. adc_data is never sampled at any other time.
- States:
  - ACCUM: waiting for or accumulating samples.
  - DUMP: one cycle that produces the output.
- Pipeline, with edge E = clock edge at which s2 first registers high:
  - E+1: sample_reg loaded.
  - E+2: acc += sample_reg; count += 1; min/max updated.
  - If count reaches N at E+2, state goes to DUMP.
  - E+3: DUMP loads the outputs, asserts avg_valid for that one cycle, and reloads acc=0, count=0, min=all-ones, max=0. State returns to ACCUM.
- Total latency: avg_valid is high in the cycle after clock edge 5, counted from the first edge at which new_data_flag is sampled high (2 sync + capture + accumulate + dump).
- Arithmetic:
  - acc width is DATA_W+LOG2_AVG, so it cannot overflow.
  - avg_data = acc[DATA_W+LOG2_AVG-1:LOG2_AVG] (truncation, no rounding).
  - LOG2_AVG=0: every sample is passed through, with avg_min = avg_max = avg_data.
- Outputs hold their values between avg_valid pulses.
- fill_count tracks count, and is 0 immediately after DUMP.
- enable low:
  - acc, count, min and max are cleared every cycle.
  - Edges are ignored, and any pipelined sample is discarded.
  - Outputs hold; no avg_valid is produced.
  - Re-enabling starts a fresh window with the next edge. The sync flops keep running, so a flag already high at re-enable is not counted.
- avg_clear: same clearing as enable low, for one cycle. A sample in the E+1/E+2 stages in that cycle is discarded. avg_clear has priority over accumulation and DUMP.
- Simultaneous events: an edge detected during DUMP is still captured and accumulates into the new window. This cannot lose data, because the minimum flag spacing is 17 SCLK periods.
- Asynchronous reset mid-window: all state returns to reset values immediately. The partial window is lost and no avg_valid is produced.

Test Plan:
- LOG2_AVG=4, 16 flags with adc_data=0x1234 -> one avg_valid; avg_data=0x1234, avg_min=avg_max=0x1234; fill_count back to 0.
- 16 samples ramping 0..15 -> avg_data=7 (120/16 truncated), avg_min=0, avg_max=15. Then 16 samples at 0xFFFF -> avg_data=0xFFFF, avg_min=avg_max=0xFFFF, no overflow.
- Single flag held high 40 cycles -> fill_count increments exactly once. avg_valid appears in the cycle after clock edge 5 of the 16th flag.
- 8 samples of 0x0100, avg_clear pulse, then 16 samples of 0x0200 -> exactly one avg_valid, with avg_data=0x0200 and avg_min=0x0200.
- enable dropped after 5 samples, raised, then 16 samples of 0x0050 -> one avg_valid, avg_data=0x0050. Asserting reset_n low mid-window -> all outputs 0 immediately, no avg_valid.
- LOG2_AVG=0, samples 0x0001, 0xABCD -> avg_valid after each sample, with avg_data=avg_min=avg_max equal to that sample.
